// File: rtl/lsr_scheduler.sv
// lsr_scheduler: two-requester round-robin front end for a multi-pass
// logical-right shifter. Each pass shifts by at most STEP_MAX bits, so a
// request of amount A takes max(1, ceil(A/STEP_MAX)) shift passes.
module lsr_scheduler #(
  parameter int WIDTH    = 32,
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] step;
  logic             id;
  logic             last_gnt;
  logic             gnt0;
  logic             gnt1;

  // Round-robin grant, only offered in IDLE and never while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (req0_valid && (!req1_valid || last_gnt))
        gnt0 = 1'b1;
      else if (req1_valid)
        gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Per-pass shift amount, clamped to the shift-unit limit.
  always_comb begin
    step = (remaining > STEP_LIM) ? STEP_LIM : remaining;
  end

  // Control FSM with registered response and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      remaining <= '0;
      id        <= 1'b0;
      last_gnt  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            data      <= gnt1 ? req1_data : req0_data;
            remaining <= gnt1 ? req1_amt : req0_amt;
            id        <= gnt1;
            last_gnt  <= gnt1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          data      <= data >> step;
          remaining <= remaining - step;
          // Final pass (also covers amount 0): publish the result directly
          // so the response is registered in the same edge as the last shift.
          if (remaining == step) begin
            rsp_valid <= 1'b1;
            rsp_data  <= data >> step;
            rsp_id    <= id;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsr_scheduler.sv
// Directed, table-driven bench for lsr_scheduler.
module tb_lsr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_data = '0;
  logic [4:0]  req0_amt = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_data = '0;
  logic [4:0]  req1_amt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic mon_on = 1'b0;

  lsr_scheduler #(.WIDTH(32), .AMT_W(5), .STEP_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Invariants sampled every cycle once out of the initial reset.
  always @(negedge clk) begin
    if (mon_on) begin
      #1;
      chk("both_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (!rsp_valid) begin
        chk("rsp_data_zero", rsp_data, 32'd0);
        chk("rsp_id_zero", {31'b0, rsp_id}, 32'd0);
      end
    end
  end

  task automatic wait_rsp(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < bound);
  endtask

  // One operation through the table; inputs are scrambled after accept.
  task automatic do_op(input vec_t v, input string nm);
    int cyc;
    @(negedge clk);
    if (v.id) begin
      req1_valid = 1'b1; req1_data = v.data; req1_amt = v.amt;
    end else begin
      req0_valid = 1'b1; req0_data = v.data; req0_amt = v.amt;
    end
    #1;
    chk({nm, "_ready"}, {31'b0, v.id ? req1_ready : req0_ready}, 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = $urandom;
      req0_amt   = 5'($urandom_range(31));
      req1_data  = $urandom;
      req1_amt   = 5'($urandom_range(31));
    end while (!rsp_valid && cyc < 20);
    chk({nm, "_lat"}, cyc, v.lat);
    chk({nm, "_data"}, rsp_data, v.exp);
    chk({nm, "_id"}, {31'b0, rsp_id}, {31'b0, v.id});
    chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk({nm, "_done_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, "_done_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 4};
    vecs[1] = '{1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 2};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 5'd15, 32'h0001_FFFF, 2};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 3};
    vecs[4] = '{1'b0, 32'h1234_5678, 5'd4,  32'h0123_4567, 2};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 5'd30, 32'h0000_0003, 3};
    vecs[6] = '{1'b1, 32'hA5A5_A5A5, 5'd8,  32'h00A5_A5A5, 2};
    vecs[7] = '{1'b0, 32'h8000_0000, 5'd1,  32'h4000_0000, 2};

    // Reset with both requesters already valid.
    #1 rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 32'd6;  req0_amt = 5'd2;
    req1_valid = 1'b1; req1_data = 32'd10; req1_amt = 5'd3;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_r0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_r1_ready", {31'b0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Arbitration after reset: req0 first, then req1.
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    #1;
    chk("arb_first_r0", {31'b0, req0_ready}, 32'd1);
    chk("arb_first_r1", {31'b0, req1_ready}, 32'd0);
    wait_rsp(10, cyc);
    chk("arb_a_lat", cyc, 32'd2);
    chk("arb_a_data", rsp_data, 32'd1);
    chk("arb_a_id", {31'b0, rsp_id}, 32'd0);
    @(negedge clk);
    #1;
    chk("arb_second_r1", {31'b0, req1_ready}, 32'd1);
    chk("arb_second_r0", {31'b0, req0_ready}, 32'd0);
    wait_rsp(10, cyc);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb_b_lat", cyc, 32'd2);
    chk("arb_b_data", rsp_data, 32'd1);
    chk("arb_b_id", {31'b0, rsp_id}, 32'd1);
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure in DONE for 5 cycles.
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'hFFFF_0000; req0_amt = 5'd8;
    wait_rsp(10, cyc);
    chk("bp_lat", cyc, 32'd2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h00FF_FF00);
      chk("bp_id", {31'b0, rsp_id}, 32'd0);
      chk("bp_r0", {31'b0, req0_ready}, 32'd0);
      chk("bp_r1", {31'b0, req1_ready}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_release_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a 3-pass shift.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h8000_0000; req0_amt = 5'd31;
    #1;
    chk("mid_accept", {31'b0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_0F00; req0_amt = 5'd8;
    req1_valid = 1'b1; req1_data = 32'h0000_0F00; req1_amt = 5'd4;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    chk("mid_rst_id", {31'b0, rsp_id}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_r0", {31'b0, req0_ready}, 32'd0);
    chk("mid_rst_r1", {31'b0, req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_hold_valid", {31'b0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_r0", {31'b0, req0_ready}, 32'd1);
    chk("post_rst_r1", {31'b0, req1_ready}, 32'd0);
    wait_rsp(10, cyc);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("post_rst_lat", cyc, 32'd2);
    chk("post_rst_data", rsp_data, 32'h0000_000F);
    chk("post_rst_id", {31'b0, rsp_id}, 32'd0);
    @(negedge clk);
    chk("post_rst_idle", {31'b0, busy}, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
